fetch_stage_ctrl: RTL

//  Fetch-stage sequencer upstream of the instruction ROM and feeding Decode.

---
 rtl/fetch_stage_ctrl_if.sv | 30 +++
 rtl/fetch_stage_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl_if.sv
// Fetch-stage bus: hazard controls, redirect, ROM address/data and IF/ID outputs.
// The master modport is the fetch stage. The slave modport is its environment:
// the hazard unit, the Execute stage, the ROM and Decode.
`timescale 1ns/1ps
interface fetch_stage_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic             PCSrcE;
   logic [WIDTH-1:0] PCTargetE;
   logic [WIDTH-1:0] PCF;
   logic [WIDTH-1:0] InstrF;
   logic [WIDTH-1:0] InstrD;
   logic [WIDTH-1:0] PCD;
   logic [WIDTH-1:0] PCPlus4D;
   logic             ValidD;
   logic             FetchFaultD;

   modport master (
      input  StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
      output PCF, InstrD, PCD, PCPlus4D, ValidD, FetchFaultD
   );

   modport slave (
      output StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
      input  PCF, InstrD, PCD, PCPlus4D, ValidD, FetchFaultD
   );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Fetch-stage sequencer. It holds the program counter that addresses the instruction
// ROM and loads the IF/ID pipeline register that feeds Decode.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, each fetch address
// is checked for word alignment and for lying inside the ROM window. A bad fetch is
// captured as a bubble with FetchFaultD set, and its PC is still recorded so a trap
// can report it.
`timescale 1ns/1ps
module fetch_stage_ctrl #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [WIDTH-1:0] ROM_END      = 32'hBFC00FFF,
   parameter logic [WIDTH-1:0] NOP_INSTR    = 32'h00000013
) (
   input  logic                 clk,
   input  logic                 rst,
   fetch_stage_ctrl_if.master   bus
);

`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   // The last address a full word can start at and still lie inside the ROM.
   localparam logic [WIDTH-1:0] LAST_WORD = ROM_END - WIDTH'(3);

   logic [WIDTH-1:0] pc_p0;
   logic [WIDTH-1:0] pc_plus4_p0;
   logic [WIDTH-1:0] pc_next_p0;
   logic             fault_p0;

   logic [WIDTH-1:0] instr_p1;
   logic [WIDTH-1:0] pc_p1;
   logic [WIDTH-1:0] pc_plus4_p1;
   logic             vld_p1;
   logic             fault_p1;

   // The sequential PC wraps modulo 2^WIDTH.
   assign pc_plus4_p0 = pc_p0 + WIDTH'(4);

   // A misaligned or out-of-window fetch is a fault. The check is only active when
   // the feature macro is defined; otherwise this signal is constant 0.
   assign fault_p0 = CHECK_EN && ((pc_p0[1:0] != 2'b00) ||
                                  (pc_p0 < RESET_VECTOR) ||
                                  (pc_p0 > LAST_WORD));

   // Next-PC select. A redirect beats a stall, so a taken branch is never lost.
   always_comb begin
      pc_next_p0 = pc_plus4_p0;
      if (bus.PCSrcE)
         pc_next_p0 = bus.PCTargetE;
      else if (bus.StallF)
         pc_next_p0 = pc_p0;
   end

   // Program counter register, with asynchronous reset to the boot vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc_p0 <= RESET_VECTOR;
      else
         pc_p0 <= pc_next_p0;
   end

   // ---- stage boundary: fetch (p0) -> IF/ID register (p1) ----
   // IF/ID register. Priority is flush (bubble), then stall (hold), then capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_p1    <= NOP_INSTR;
         pc_p1       <= '0;
         pc_plus4_p1 <= '0;
         vld_p1      <= 1'b0;
         fault_p1    <= 1'b0;
      end else if (bus.FlushD) begin
         instr_p1    <= NOP_INSTR;
         pc_p1       <= '0;
         pc_plus4_p1 <= '0;
         vld_p1      <= 1'b0;
         fault_p1    <= 1'b0;
      end else if (!bus.StallD) begin
         instr_p1    <= fault_p0 ? NOP_INSTR : bus.InstrF;
         pc_p1       <= pc_p0;
         pc_plus4_p1 <= pc_plus4_p0;
         vld_p1      <= !fault_p0;
         fault_p1    <= fault_p0;
      end
   end

   assign bus.PCF         = pc_p0;
   assign bus.InstrD      = instr_p1;
   assign bus.PCD         = pc_p1;
   assign bus.PCPlus4D    = pc_plus4_p1;
   assign bus.ValidD      = vld_p1;
   assign bus.FetchFaultD = fault_p1;

endmodule
